// File: rtl/led_seq_pkg.sv
// Shared FSM state encodings and default parameter constants for the LED
// sequencing controller.
package led_seq_pkg;

  localparam int DEF_PHASE_CYC  = 12_000_000;
  localparam int DEF_BLINKS     = 4;
  localparam int DEF_DEB_CYCLES = 240_000;

  // state   | meaning
  // IDLE    | waiting for a request, LED off
  // ON      | LED lit for one phase
  // OFF     | LED dark for one phase
  // DONE    | one-cycle completion pulse, may relaunch a queued burst
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-FF synchroniser, optional debounce stage and rising-edge
// detector. The debounce stage is built only when LED_SEQ_DEBOUNCE_EN is defined.
module btn_debounce
  import led_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int DW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LD = DW'(DEB_CYCLES);

  logic          r_level;
  logic [DW-1:0] r_deb_cnt;

  // The counter is reloaded while the input agrees with the accepted level, so
  // a level change must survive DEB_CYCLES consecutive cycles to be accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level   <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_level) begin
      r_deb_cnt <= DEB_LD;
    end else if (r_deb_cnt <= DW'(1)) begin
      r_level   <= r_sync2;
      r_deb_cnt <= DEB_LD;
    end else begin
      r_deb_cnt <= r_deb_cnt - DW'(1);
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_level;
  end

  assign press = w_level & ~r_prev;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED blink-burst sequencer: FSM, phase/pair down-counters and a one-deep request
// queue. Button debounce is enabled by defining LED_SEQ_DEBOUNCE_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int PHASE_CYC  = DEF_PHASE_CYC,
  parameter int BLINKS     = DEF_BLINKS,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic start,
  output logic led_drive,
  output logic busy,
  output logic done
);

  localparam int PW = $clog2(PHASE_CYC);
  localparam logic [PW-1:0] PHASE_LD = PW'(PHASE_CYC - 1);
  localparam logic [7:0]    PAIR_LD  = 8'(BLINKS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_nxt;
  logic [7:0]    r_pair;
  logic [7:0]    w_pair_nxt;
  logic          r_pending;
  logic          w_pending_nxt;
  logic          w_press;
  logic          w_req;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn_in(btn_in),
    .press (w_press)
  );

  assign w_req = start | w_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_pair    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_phase   <= w_phase_nxt;
      r_pair    <= w_pair_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  always_comb begin
    w_next        = r_state;
    w_phase_nxt   = r_phase;
    w_pair_nxt    = r_pair;
    w_pending_nxt = r_pending;
    led_drive     = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next      = ST_ON;
          w_phase_nxt = PHASE_LD;
          w_pair_nxt  = PAIR_LD;
        end
      end
      ST_ON: begin
        led_drive = 1'b1;
        busy      = 1'b1;
        if (w_req) w_pending_nxt = 1'b1;
        if (r_phase == '0) begin
          w_next      = ST_OFF;
          w_phase_nxt = PHASE_LD;
        end else begin
          w_phase_nxt = r_phase - PW'(1);
        end
      end
      ST_OFF: begin
        busy = 1'b1;
        if (w_req) w_pending_nxt = 1'b1;
        if (r_phase == '0) begin
          if (r_pair == '0) begin
            w_next = ST_DONE;
          end else begin
            w_next      = ST_ON;
            w_pair_nxt  = r_pair - 8'd1;
            w_phase_nxt = PHASE_LD;
          end
        end else begin
          w_phase_nxt = r_phase - PW'(1);
        end
      end
      ST_DONE: begin
        done = 1'b1;
        // A request landing in DONE is queued and consumed in the same cycle;
        // if one was already queued, the new one re-arms the queue.
        if (r_pending | w_req) begin
          w_next        = ST_ON;
          w_phase_nxt   = PHASE_LD;
          w_pair_nxt    = PAIR_LD;
          w_pending_nxt = r_pending & w_req;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios plus a randomized
// start stream checked against a burst-timeline reference model.
module tb_led_seq_ctrl;

  localparam int P  = 4;
  localparam int B  = 2;
  localparam int D  = 3;
  localparam int BP = 2 * B * P;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic start;
  logic led_drive;
  logic busy;
  logic done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(
    .PHASE_CYC (P),
    .BLINKS    (B),
    .DEB_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .start    (start),
    .led_drive(led_drive),
    .busy     (busy),
    .done     (done)
  );

  function automatic bit in_rng(int c, int lo, int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  task automatic do_reset;
    rst    = 1'b1;
    start  = 1'b0;
    btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    start  = 1'b0;
    btn_in = 1'b0;
    #1;
    tests_run++;
    if ({led_drive, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%b exp=000", {led_drive, busy, done});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({led_drive, busy, done} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_idle got=%b exp=000", {led_drive, busy, done});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_single_burst;
    bit e_led, e_busy, e_done;
    for (int c = 0; c <= 22; c++) begin
      start = (c == 0);
      @(negedge clk);
      e_led  = in_rng(c, 1, 4) || in_rng(c, 9, 12);
      e_busy = in_rng(c, 1, 16);
      e_done = (c == 17);
      tests_run++;
      if (led_drive !== e_led) begin
        tests_failed++;
        $display("FAIL single_led c=%0d got=%b exp=%b", c, led_drive, e_led);
      end
      tests_run++;
      if (busy !== e_busy) begin
        tests_failed++;
        $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, e_busy);
      end
      tests_run++;
      if (done !== e_done) begin
        tests_failed++;
        $display("FAIL single_done c=%0d got=%b exp=%b", c, done, e_done);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_queued;
    bit e_led, e_busy, e_done;
    for (int c = 0; c <= 37; c++) begin
      start = (c == 0) || (c == 6);
      @(negedge clk);
      e_led  = in_rng(c, 1, 4) || in_rng(c, 9, 12) || in_rng(c, 18, 21) || in_rng(c, 26, 29);
      e_busy = in_rng(c, 1, 16) || in_rng(c, 18, 33);
      e_done = (c == 17) || (c == 34);
      tests_run++;
      if (led_drive !== e_led) begin
        tests_failed++;
        $display("FAIL queued_led c=%0d got=%b exp=%b", c, led_drive, e_led);
      end
      tests_run++;
      if (busy !== e_busy) begin
        tests_failed++;
        $display("FAIL queued_busy c=%0d got=%b exp=%b", c, busy, e_busy);
      end
      tests_run++;
      if (done !== e_done) begin
        tests_failed++;
        $display("FAIL queued_done c=%0d got=%b exp=%b", c, done, e_done);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_drop;
    int  n_done = 0;
    int  n_burst = 0;
    int  d1 = -1;
    int  d2 = -1;
    bit  prev_busy = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      start = (c == 3) || (c == 6) || (c == 8);
      @(negedge clk);
      if (busy && !prev_busy) n_burst++;
      prev_busy = busy;
      if (done) begin
        n_done++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    tests_run++;
    if (n_burst != 2) begin
      tests_failed++;
      $display("FAIL drop_bursts got=%0d exp=2", n_burst);
    end
    tests_run++;
    if (n_done != 2) begin
      tests_failed++;
      $display("FAIL drop_done_count got=%0d exp=2", n_done);
    end
    tests_run++;
    if (d1 != 20 || d2 != 37) begin
      tests_failed++;
      $display("FAIL drop_done_cycles got=%0d,%0d exp=20,37", d1, d2);
    end
  endtask

  task automatic test_button;
    int first_led = -1;
    int n_done = 0;
    int n_busy = 0;
    int exp_first;
    int exp_glitch_busy;
`ifdef LED_SEQ_DEBOUNCE_EN
    exp_first       = 6;
    exp_glitch_busy = 0;
`else
    exp_first       = 3;
    exp_glitch_busy = BP;
`endif
    for (int c = 0; c <= 30; c++) begin
      btn_in = (c < 10);
      @(negedge clk);
      if (led_drive && first_led < 0) first_led = c;
      if (done) n_done++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (first_led != exp_first) begin
      tests_failed++;
      $display("FAIL button_latency got=%0d exp=%0d", first_led, exp_first);
    end
    tests_run++;
    if (n_done != 1) begin
      tests_failed++;
      $display("FAIL button_single_press got=%0d exp=1", n_done);
    end
    for (int c = 0; c <= 25; c++) begin
      btn_in = (c < 2);
      @(negedge clk);
      if (busy) n_busy++;
      @(posedge clk);
      #1;
    end
    btn_in = 1'b0;
    tests_run++;
    if (n_busy != exp_glitch_busy) begin
      tests_failed++;
      $display("FAIL button_glitch busy_cycles got=%0d exp=%0d", n_busy, exp_glitch_busy);
    end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c <= 1; c++) begin
      start = 1'b1;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    #1;
    tests_run++;
    if (led_drive !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre_led got=%b exp=1", led_drive);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({led_drive, busy, done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rstmid_async got=%b exp=000", {led_drive, busy, done});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || led_drive !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_no_burst c=%0d busy=%b led=%b exp=0,0", c, busy, led_drive);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // Reference: a burst is a timeline starting at cycle m_st; outputs are pure
  // arithmetic on the offset, and one request may be queued until the end.
  task automatic test_random;
    bit m_active = 1'b0;
    bit m_pend   = 1'b0;
    int m_st     = 0;
    int p;
    bit e_led, e_busy, e_done, r;
    do_reset();
    for (int t = 0; t < 600; t++) begin
      r     = ($urandom_range(0, 5) == 0);
      start = r;
      @(negedge clk);
      e_led = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      p = t - m_st;
      if (m_active) begin
        if (p < BP) begin
          e_busy = 1'b1;
          e_led  = ((p / P) % 2) == 0;
        end else begin
          e_done = 1'b1;
        end
      end
      tests_run++;
      if ({led_drive, busy, done} !== {e_led, e_busy, e_done}) begin
        tests_failed++;
        $display("FAIL random t=%0d led/busy/done got=%b exp=%b", t,
                 {led_drive, busy, done}, {e_led, e_busy, e_done});
      end
      if (!m_active) begin
        if (r) begin
          m_active = 1'b1;
          m_st     = t + 1;
        end
      end else if (p < BP) begin
        if (r) m_pend = 1'b1;
      end else begin
        if (m_pend || r) begin
          m_st   = t + 1;
          m_pend = m_pend && r;
        end else begin
          m_active = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_queued();
    test_drop();
    test_button();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
